// File: rtl/caf_pkg.sv
// Shared CAF definitions: scheduler FSM states, width helpers, peak-result record.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package caf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_STREAM,
    ST_WAIT_RES,
    ST_CAPTURE,
    ST_DONE
  } caf_state_e;

  // Lag index must cover 0..2*LENGTH-2, hence one bit beyond the sample address.
  function automatic int caf_index_bits(input int length);
    return $clog2(length) + 1;
  endfunction

  // Bin number width; a single-bin sweep still needs a 1-bit field.
  function automatic int caf_bin_bits(input int num_bins);
    return (num_bins > 1) ? $clog2(num_bins) : 1;
  endfunction

  localparam int CAF_DEF_LENGTH       = 64;
  localparam int CAF_DEF_NUM_BINS     = 8;
  localparam int CAF_DEF_OUT_MAX_BITS = 32;
  localparam int CAF_DEF_INDEX_BITS   = caf_index_bits(CAF_DEF_LENGTH);
  localparam int CAF_DEF_BIN_BITS     = caf_bin_bits(CAF_DEF_NUM_BINS);

  // Peak record at the default surface geometry, for consumers of a full sweep.
  typedef struct packed {
    logic [CAF_DEF_OUT_MAX_BITS-1:0] max;
    logic [CAF_DEF_INDEX_BITS-1:0]   index;
    logic [CAF_DEF_BIN_BITS-1:0]     bin;
  } caf_peak_t;

endpackage

// File: rtl/caf_peak_tracker.sv
// Compare-and-hold of the best (max, index, bin) seen since the last clear.
// Latency: candidate lands in best_* one cycle after upd_en.
// Backpressure: none; every upd_en is evaluated in its own cycle.
module caf_peak_tracker #(
  parameter int MAX_BITS = 32,
  parameter int IDX_BITS = 7,
  parameter int BIN_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                upd_en,
  input  logic                force_upd,
  input  logic [MAX_BITS-1:0] cand_max,
  input  logic [IDX_BITS-1:0] cand_index,
  input  logic [BIN_BITS-1:0] cand_bin,
  output logic [MAX_BITS-1:0] best_max,
  output logic [IDX_BITS-1:0] best_index,
  output logic [BIN_BITS-1:0] best_bin
);

  logic [MAX_BITS-1:0] best_max_q, best_max_d;
  logic [IDX_BITS-1:0] best_index_q, best_index_d;
  logic [BIN_BITS-1:0] best_bin_q, best_bin_d;

  // Strictly-greater unsigned compare so ties keep the earlier candidate.
  always_comb begin
    best_max_d   = best_max_q;
    best_index_d = best_index_q;
    best_bin_d   = best_bin_q;
    if (clear) begin
      best_max_d   = '0;
      best_index_d = '0;
      best_bin_d   = '0;
    end else if (upd_en && (force_upd || (cand_max > best_max_q))) begin
      best_max_d   = cand_max;
      best_index_d = cand_index;
      best_bin_d   = cand_bin;
    end
  end

  // Best-so-far registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_max_q   <= '0;
      best_index_q <= '0;
      best_bin_q   <= '0;
    end else begin
      best_max_q   <= best_max_d;
      best_index_q <= best_index_d;
      best_bin_q   <= best_bin_d;
    end
  end

  assign best_max   = best_max_q;
  assign best_index = best_index_q;
  assign best_bin   = best_bin_q;

endmodule

// File: rtl/caf_bin_scheduler.sv
// Sweeps one shared x_corr across NUM_BINS Doppler bins and keeps the global peak.
// Latency: per bin 1+SETTLE_CYCLES+LENGTH+xcorr+1 cycles, sweep NUM_BINS*bin+1.
// Backpressure: stalls on xc_in_ready, waits on xc_out_valid; CAF_BIN_LOG_EN adds a per-bin log.
module caf_bin_scheduler
  import caf_pkg::*;
#(
  parameter int NUM_BINS      = 8,
  parameter int LENGTH        = 64,
  parameter int OUT_MAX_BITS  = 32,
  parameter int INDEX_BITS    = caf_index_bits(LENGTH),
  parameter int FREQ_BITS     = 16,
  parameter int SETTLE_CYCLES = 4,
  localparam int AW = $clog2(LENGTH),
  localparam int BW = caf_bin_bits(NUM_BINS),
  localparam int SW = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [FREQ_BITS-1:0]    freq_start,
  input  logic [FREQ_BITS-1:0]    freq_step,
  output logic                    busy,
  output logic                    done,
  output logic [FREQ_BITS-1:0]    freq_word,
  output logic                    freq_load,
  output logic [AW-1:0]           sample_addr,
  output logic                    xc_in_valid,
  input  logic                    xc_in_ready,
  input  logic                    xc_out_valid,
  input  logic [OUT_MAX_BITS-1:0] xc_out_max,
  input  logic [INDEX_BITS-1:0]   xc_out_index,
  output logic                    xc_out_ready,
`ifdef CAF_BIN_LOG_EN
  output logic                    bin_log_valid,
  output logic [OUT_MAX_BITS-1:0] bin_log_max,
  output logic [INDEX_BITS-1:0]   bin_log_index,
  output logic [BW-1:0]           bin_log_bin,
`endif
  output logic [OUT_MAX_BITS-1:0] best_max,
  output logic [INDEX_BITS-1:0]   best_index,
  output logic [BW-1:0]           best_bin
);

  caf_state_e              state_q, state_d;
  logic [BW-1:0]           bin_q, bin_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [AW-1:0]           samp_q, samp_d;
  logic [FREQ_BITS-1:0]    freq_q, freq_d;
  logic [FREQ_BITS-1:0]    step_q, step_d;
  logic [OUT_MAX_BITS-1:0] res_max_q, res_max_d;
  logic [INDEX_BITS-1:0]   res_idx_q, res_idx_d;
  logic                    trk_clear;

  // Sweep sequencing; freq word advances by one step per bin so no multiplier is needed.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    settle_d  = settle_q;
    samp_d    = samp_q;
    freq_d    = freq_q;
    step_d    = step_q;
    res_max_d = res_max_q;
    res_idx_d = res_idx_q;
    trk_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          freq_d    = freq_start;
          step_d    = freq_step;
          bin_d     = '0;
          settle_d  = '0;
          samp_d    = '0;
          trk_clear = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          samp_d   = '0;
          state_d  = ST_STREAM;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      ST_STREAM: begin
        if (xc_in_ready) begin
          if (samp_q == AW'(LENGTH - 1)) begin
            samp_d  = '0;
            state_d = ST_WAIT_RES;
          end else begin
            samp_d = samp_q + AW'(1);
          end
        end
      end
      ST_WAIT_RES: begin
        // Result is held locally because x_corr may drop it after the handshake.
        if (xc_out_valid) begin
          res_max_d = xc_out_max;
          res_idx_d = xc_out_index;
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (bin_q == BW'(NUM_BINS - 1)) begin
          state_d = ST_DONE;
        end else begin
          bin_d   = bin_q + BW'(1);
          freq_d  = freq_q + step_q;
          state_d = ST_LOAD;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and per-bin registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      settle_q  <= '0;
      samp_q    <= '0;
      freq_q    <= '0;
      step_q    <= '0;
      res_max_q <= '0;
      res_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      settle_q  <= settle_d;
      samp_q    <= samp_d;
      freq_q    <= freq_d;
      step_q    <= step_d;
      res_max_q <= res_max_d;
      res_idx_q <= res_idx_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign freq_load    = (state_q == ST_LOAD);
  assign freq_word    = freq_q;
  assign xc_in_valid  = (state_q == ST_STREAM);
  assign sample_addr  = samp_q;
  assign xc_out_ready = (state_q == ST_WAIT_RES);

`ifdef CAF_BIN_LOG_EN
  assign bin_log_valid = (state_q == ST_CAPTURE);
  assign bin_log_max   = res_max_q;
  assign bin_log_index = res_idx_q;
  assign bin_log_bin   = bin_q;
`endif

  caf_peak_tracker #(
    .MAX_BITS (OUT_MAX_BITS),
    .IDX_BITS (INDEX_BITS),
    .BIN_BITS (BW)
  ) u_peak (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (trk_clear),
    .upd_en     (state_q == ST_CAPTURE),
    .force_upd  (bin_q == '0),
    .cand_max   (res_max_q),
    .cand_index (res_idx_q),
    .cand_bin   (bin_q),
    .best_max   (best_max),
    .best_index (best_index),
    .best_bin   (best_bin)
  );

endmodule
